// File: rtl/draw_sequencer.sv
// draw_sequencer: per-frame scheduler that runs the clear pass, then the sine pass, and
// grants the framebuffer write port to one engine at a time.
// Latency: an accepted pixel appears on fb_* one cycle after its accept.
// Backpressure: the active engine's ready drops while a pending fb write is stalled by fb_ready=0.
// Optional: define DRAW_SEQ_OVERRUN_CNT_EN to add overrun_cnt, a saturating count of
// frame_tick pulses that arrive while a pass is still running.
module draw_sequencer #(
  parameter int CLEAR_PIXELS = 19200,
  parameter int DRAW_PIXELS  = 160,
  parameter int CW           = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        frame_tick,
  output logic        clr_start,
  input  logic        clr_valid,
  input  logic [7:0]  clr_x,
  input  logic [7:0]  clr_y,
  input  logic [11:0] clr_color,
  output logic        clr_ready,
  output logic        sin_start,
  input  logic        sin_valid,
  input  logic [7:0]  sin_x,
  input  logic [7:0]  sin_y,
  input  logic [11:0] sin_color,
  output logic        sin_ready,
  output logic        fb_we,
  output logic [7:0]  fb_x,
  output logic [7:0]  fb_y,
  output logic [11:0] fb_color,
  input  logic        fb_ready,
`ifdef DRAW_SEQ_OVERRUN_CNT_EN
  output logic [7:0]  overrun_cnt,
`endif
  output logic        busy,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_DRAW  = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_go_clear;
  logic [CW-1:0] r_cnt;
  logic          r_clr_start;
  logic          r_sin_start;
  logic          r_fb_we;
  logic [7:0]    r_fb_x;
  logic [7:0]    r_fb_y;
  logic [11:0]   r_fb_color;
  logic          w_out_free;
  logic          w_clr_acc;
  logic          w_sin_acc;
  logic          w_clr_last;
  logic          w_sin_last;

  // The single output register can take a new pixel when empty or when it drains this cycle.
  assign w_out_free = !r_fb_we || fb_ready;
  assign clr_ready  = (r_state == S_CLEAR) && w_out_free;
  assign sin_ready  = (r_state == S_DRAW) && w_out_free;
  assign w_clr_acc  = clr_valid && clr_ready;
  assign w_sin_acc  = sin_valid && sin_ready;
  assign w_clr_last = (r_cnt == CW'(CLEAR_PIXELS - 1));
  assign w_sin_last = (r_cnt == CW'(DRAW_PIXELS - 1));

  assign busy      = (r_state == S_CLEAR) || (r_state == S_DRAW);
  assign state     = r_state;
  assign clr_start = r_clr_start;
  assign sin_start = r_sin_start;
  assign fb_we     = r_fb_we;
  assign fb_x      = r_fb_x;
  assign fb_y      = r_fb_y;
  assign fb_color  = r_fb_color;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: passes run to completion; enable is only looked at in IDLE and WAIT.
  always_comb begin
    w_state_nxt = r_state;
    w_go_clear  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable) begin
          w_state_nxt = S_CLEAR;
          w_go_clear  = 1'b1;
        end
      end
      S_CLEAR: begin
        if (w_clr_acc && w_clr_last) begin
          w_state_nxt = S_DRAW;
        end
      end
      S_DRAW: begin
        if (w_sin_acc && w_sin_last) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!enable) begin
          w_state_nxt = S_IDLE;
        end else if (frame_tick) begin
          w_state_nxt = S_CLEAR;
          w_go_clear  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Pixel counter: counts accepts within a pass, cleared on the pass's last accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if ((w_clr_acc && w_clr_last) || (w_sin_acc && w_sin_last)) begin
      r_cnt <= '0;
    end else if (w_clr_acc || w_sin_acc) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Engine start pulses, registered so they appear the cycle after the pass begins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clr_start <= 1'b0;
      r_sin_start <= 1'b0;
    end else begin
      r_clr_start <= w_go_clear;
      r_sin_start <= w_clr_acc && w_clr_last;
    end
  end

  // Output stage: load on accept, hold while stalled, drop strobe once the write completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fb_we    <= 1'b0;
      r_fb_x     <= '0;
      r_fb_y     <= '0;
      r_fb_color <= '0;
    end else if (w_clr_acc) begin
      r_fb_we    <= 1'b1;
      r_fb_x     <= clr_x;
      r_fb_y     <= clr_y;
      r_fb_color <= clr_color;
    end else if (w_sin_acc) begin
      r_fb_we    <= 1'b1;
      r_fb_x     <= sin_x;
      r_fb_y     <= sin_y;
      r_fb_color <= sin_color;
    end else if (fb_ready) begin
      r_fb_we    <= 1'b0;
    end
  end

`ifdef DRAW_SEQ_OVERRUN_CNT_EN
  logic [7:0] r_overrun_cnt;
  assign overrun_cnt = r_overrun_cnt;

  // Count frame ticks that land while a pass is still running; saturate at 255.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun_cnt <= '0;
    end else if (frame_tick && busy && (r_overrun_cnt != 8'hFF)) begin
      r_overrun_cnt <= r_overrun_cnt + 8'd1;
    end
  end
`endif

endmodule
